message_stream_splitter: RTL and testbench

- Demultiplexes one message stream into N_STREAMS output message streams. It is the counterpart of the N-to-1 message stream combiner.
- The header word of each packet carries a destination stream index. The whole packet (header plus payload) is routed to that output lane.
- It sits downstream of a combiner or a host link and feeds per-channel processing blocks.
- No backpressure anywhere: in_nd and out_nd are single-cycle valid strobes, matching the rest of the message fabric.

---
 rtl/message_pkg.sv | 30 +++
 rtl/message_header_parser.sv | 28 ++
 rtl/message_stream_splitter.sv | 122 ++++++++++++
 tb/tb_message_stream_splitter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/message_pkg.sv
// Shared definitions for the message fabric: header field layout,
// splitter FSM states and per-lane packet counter width.
package message_pkg;

    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FORWARD,
        DROP
    } state_t;

    function automatic int hdr_bit(input int width);
        return width - 1;
    endfunction

    function automatic int len_msb(input int width);
        return width - 2;
    endfunction

    function automatic int dest_msb(input int width, input int log_len);
        return width - 2 - log_len;
    endfunction

    function automatic bit header_fits(input int width, input int log_len,
                                       input int log_n);
        return width >= 1 + log_len + log_n;
    endfunction

endpackage

// File: rtl/message_header_parser.sv
// Combinational header field extraction, shared by splitter and combiner.
// Payload words pass through it too; the caller decides what is a header.
module message_header_parser
    import message_pkg::*;
#(
    parameter int WIDTH                 = 32,
    parameter int LOG_MAX_PACKET_LENGTH = 10,
    parameter int LOG_N_STREAMS         = 2
) (
    input  logic [WIDTH-1:0]                 word,
    output logic                             is_header,
    output logic [LOG_MAX_PACKET_LENGTH-1:0] length,
    output logic [LOG_N_STREAMS-1:0]         dest
);

    localparam int HB = hdr_bit(WIDTH);
    localparam int LM = len_msb(WIDTH);
    localparam int DM = dest_msb(WIDTH, LOG_MAX_PACKET_LENGTH);

    // Bits below the dest field are don't-care in a header.
    logic unused_word;

    assign is_header   = word[HB];
    assign length      = word[LM -: LOG_MAX_PACKET_LENGTH];
    assign dest        = word[DM -: LOG_N_STREAMS];
    assign unused_word = ^word;

endmodule

// File: rtl/message_stream_splitter.sv
// 1-to-N message demultiplexer routing whole packets by header dest field.
// Optional per-lane packet counters: MESSAGE_STREAM_SPLITTER_COUNT_EN.
module message_stream_splitter
    import message_pkg::*;
#(
    parameter int N_STREAMS             = 4,
    parameter int LOG_N_STREAMS         = 2,
    parameter int WIDTH                 = 32,
    parameter int MAX_PACKET_LENGTH     = 1024,
    parameter int LOG_MAX_PACKET_LENGTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_nd,
    output logic [WIDTH*N_STREAMS-1:0]   out_data,
    output logic [N_STREAMS-1:0]         out_nd,
`ifdef MESSAGE_STREAM_SPLITTER_COUNT_EN
    output logic [COUNT_W*N_STREAMS-1:0] packet_count,
`endif
    output logic                         error
);

    localparam int LML = LOG_MAX_PACKET_LENGTH;
    localparam int LNS = LOG_N_STREAMS;
    localparam logic [LML-1:0] ONE = 1;

    // Reject configurations whose header cannot be encoded.
    if (!header_fits(WIDTH, LML, LNS)) begin : g_bad_width
        $error("WIDTH too small for header fields");
    end
    if ((1 << LNS) < N_STREAMS) begin : g_bad_dest
        $error("LOG_N_STREAMS too small for N_STREAMS");
    end
    if (MAX_PACKET_LENGTH > (1 << LML)) begin : g_bad_len
        $error("LOG_MAX_PACKET_LENGTH too small");
    end

    state_t         state;
    logic [LML-1:0] remaining;
    logic [LNS-1:0] dest;

    logic           hdr_is;
    logic [LML-1:0] hdr_len;
    logic [LNS-1:0] hdr_dest;
    logic           dest_ok;

    message_header_parser #(
        .WIDTH                 (WIDTH),
        .LOG_MAX_PACKET_LENGTH (LML),
        .LOG_N_STREAMS         (LNS)
    ) u_parser (
        .word      (in_data),
        .is_header (hdr_is),
        .length    (hdr_len),
        .dest      (hdr_dest)
    );

    // Lanes beyond N_STREAMS are unreachable; such packets get dropped.
    assign dest_ok = int'(hdr_dest) < N_STREAMS;

    // Packet FSM with registered lane outputs; lanes hold data when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            dest      <= '0;
            out_data  <= '0;
            out_nd    <= '0;
            error     <= 1'b0;
`ifdef MESSAGE_STREAM_SPLITTER_COUNT_EN
            packet_count <= '0;
`endif
        end else begin
            out_nd <= '0;
            if (in_nd) begin
                unique case (state)
                    IDLE: begin
                        if (!hdr_is) begin
                            error <= 1'b1;
                        end else if (dest_ok) begin
                            out_data[WIDTH*int'(hdr_dest) +: WIDTH] <= in_data;
                            out_nd[hdr_dest] <= 1'b1;
`ifdef MESSAGE_STREAM_SPLITTER_COUNT_EN
                            packet_count[COUNT_W*int'(hdr_dest) +: COUNT_W] <=
                                packet_count[COUNT_W*int'(hdr_dest) +: COUNT_W]
                                + 16'd1;
`endif
                            if (hdr_len != '0) begin
                                dest      <= hdr_dest;
                                remaining <= hdr_len;
                                state     <= FORWARD;
                            end
                        end else begin
                            error <= 1'b1;
                            if (hdr_len != '0) begin
                                remaining <= hdr_len;
                                state     <= DROP;
                            end
                        end
                    end
                    FORWARD: begin
                        out_data[WIDTH*int'(dest) +: WIDTH] <= in_data;
                        out_nd[dest] <= 1'b1;
                        remaining    <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= IDLE;
                        end
                    end
                    DROP: begin
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_message_stream_splitter.sv
// Scoreboard bench for message_stream_splitter: a 4-lane and a 3-lane DUT.
// Counter checks compile in with MESSAGE_STREAM_SPLITTER_COUNT_EN.
module tb_message_stream_splitter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  in_data, in_data3;
    logic         in_nd, in_nd3;
    logic [127:0] out_data;
    logic [3:0]   out_nd;
    logic         error;
    logic [95:0]  out_data3;
    logic [2:0]   out_nd3;
    logic         error3;
`ifdef MESSAGE_STREAM_SPLITTER_COUNT_EN
    logic [63:0]  packet_count;
    logic [47:0]  packet_count3;
`endif

    message_stream_splitter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_nd    (in_nd),
        .out_data (out_data),
        .out_nd   (out_nd),
`ifdef MESSAGE_STREAM_SPLITTER_COUNT_EN
        .packet_count (packet_count),
`endif
        .error    (error)
    );

    message_stream_splitter #(.N_STREAMS(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data3),
        .in_nd    (in_nd3),
        .out_data (out_data3),
        .out_nd   (out_nd3),
`ifdef MESSAGE_STREAM_SPLITTER_COUNT_EN
        .packet_count (packet_count3),
`endif
        .error    (error3)
    );

    typedef struct {
        int          lane;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every out_nd pulse must match the oldest expectation,
    // including the exact cycle it was due.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if ($countones(out_nd) > 1 || $countones(out_nd3) > 1) begin
                failures++;
                $display("FAIL onehot out_nd=%b out_nd3=%b required <=1 bit",
                         out_nd, out_nd3);
            end
            for (int k = 0; k < 4; k++) begin
                if (out_nd[k]) begin
                    checks++;
                    if (q0.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected4 lane=%0d data=%h", k,
                                 out_data[32*k +: 32]);
                    end else begin
                        e = q0.pop_front();
                        if (e.lane != k || out_data[32*k +: 32] !== e.data ||
                            e.cyc != cyc) begin
                            failures++;
                            $display("FAIL out4 lane=%0d data=%h cyc=%0d required lane=%0d data=%h cyc=%0d",
                                     k, out_data[32*k +: 32], cyc,
                                     e.lane, e.data, e.cyc);
                        end
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (out_nd3[k]) begin
                    checks++;
                    if (q1.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected3 lane=%0d data=%h", k,
                                 out_data3[32*k +: 32]);
                    end else begin
                        e = q1.pop_front();
                        if (e.lane != k || out_data3[32*k +: 32] !== e.data ||
                            e.cyc != cyc) begin
                            failures++;
                            $display("FAIL out3 lane=%0d data=%h cyc=%0d required lane=%0d data=%h cyc=%0d",
                                     k, out_data3[32*k +: 32], cyc,
                                     e.lane, e.data, e.cyc);
                        end
                    end
                end
            end
        end
    end

    // Drive one word on a negedge; lane < 0 means no output is expected.
    task automatic drive(input int sel, input logic [31:0] w, input int lane);
        if (sel == 0) begin
            in_data = w;
            in_nd   = 1'b1;
            if (lane >= 0) q0.push_back('{lane, w, cyc + 1});
        end else begin
            in_data3 = w;
            in_nd3   = 1'b1;
            if (lane >= 0) q1.push_back('{lane, w, cyc + 1});
        end
        @(negedge clk);
        in_nd  = 1'b0;
        in_nd3 = 1'b0;
    endtask

    task automatic idle(input int n);
        in_nd  = 1'b0;
        in_nd3 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if (out_nd !== 4'b0 || out_data !== 128'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state nd=%b data=%h err=%b required 0",
                     out_nd, out_data, error);
        end
        checks++;
        if (out_nd3 !== 3'b0 || out_data3 !== 96'b0 || error3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state3 nd=%b err=%b required 0",
                     out_nd3, error3);
        end
    endtask

    task automatic test_basic;
        drive(0, 32'h80700000, 2);
        drive(0, 32'h00000011, 2);
        drive(0, 32'h00000022, 2);
        drive(0, 32'h00000033, 2);
        idle(3);
        checks++;
        if (q0.size() != 0) begin
            failures++;
            $display("FAIL basic_drain left=%0d required 0", q0.size());
        end
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL basic_error err=%b required 0", error);
        end
        checks++;
        if (out_data[95:64] !== 32'h33 || out_data[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL basic_hold lane2=%h lane0=%h required 00000033 0",
                     out_data[95:64], out_data[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        drive(0, 32'h80080000, 1);
        drive(0, 32'h80700000, 2);
        drive(0, 32'h000000AA, 2);
        drive(0, 32'h000000BB, 2);
        drive(0, 32'h000000CC, 2);
        idle(3);
        checks++;
        if (q0.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain left=%0d required 0", q0.size());
        end
    endtask

    task automatic test_opaque_payload;
        drive(0, 32'h80700000, 2);
        drive(0, 32'h80000000, 2);
        drive(0, 32'h00000044, 2);
        drive(0, 32'h00000055, 2);
        drive(0, 32'h80080000, 1);
        idle(3);
        checks++;
        if (q0.size() != 0 || error !== 1'b0) begin
            failures++;
            $display("FAIL opaque left=%0d err=%b required 0 0",
                     q0.size(), error);
        end
    endtask

    task automatic test_non_header;
        drive(0, 32'h00000005, -1);
        idle(2);
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL nonhdr_error err=%b required 1", error);
        end
        drive(0, 32'h80080000, 1);
        idle(3);
        checks++;
        if (error !== 1'b1 || q0.size() != 0) begin
            failures++;
            $display("FAIL nonhdr_sticky err=%b left=%0d required 1 0",
                     error, q0.size());
        end
    endtask

    task automatic test_drop;
        drive(1, 32'h80580000, -1);
        drive(1, 32'h00000001, -1);
        drive(1, 32'h00000002, -1);
        drive(1, 32'h80080000, 1);
        idle(3);
        checks++;
        if (error3 !== 1'b1 || q1.size() != 0) begin
            failures++;
            $display("FAIL drop err3=%b left=%0d required 1 0",
                     error3, q1.size());
        end
    endtask

    task automatic test_reset_mid_packet;
        drive(0, 32'h80700000, 2);
        drive(0, 32'h00000011, 2);
        in_data = 32'h00000022;
        in_nd   = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (out_nd !== 4'b0100) begin
            failures++;
            $display("FAIL pre_reset_nd nd=%b required 0100", out_nd);
        end
        rst_n = 1'b0;
        in_nd = 1'b0;
        #1;
        checks++;
        if (out_nd !== 4'b0 || out_data !== 128'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL async_reset nd=%b data=%h err=%b required 0",
                     out_nd, out_data, error);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 32'h80080000, 1);
        idle(3);
        checks++;
        if (q0.size() != 0 || error !== 1'b0) begin
            failures++;
            $display("FAIL post_reset left=%0d err=%b required 0 0",
                     q0.size(), error);
        end
`ifdef MESSAGE_STREAM_SPLITTER_COUNT_EN
        checks++;
        if (packet_count !== 64'h0000_0000_0001_0000) begin
            failures++;
            $display("FAIL count value=%h required 0000000000010000",
                     packet_count);
        end
`endif
    endtask

    initial begin
        in_data  = '0;
        in_nd    = 1'b0;
        in_data3 = '0;
        in_nd3   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_basic;
        test_back_to_back;
        test_opaque_payload;
        test_non_header;
        test_drop;
        test_reset_mid_packet;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
